spi_arbiter: RTL

Round-robin arbiter and transaction sequencer that shares the single SPI master engine between up to `N_REQ` requesters, e.g. the CPU coprocessor SPI register file and a background poller. Each requester submits one 32-bit MOSI word and receives the matching 32-bit MISO word. The block owns the engine's load handshake, waits for receive completion, routes the response to the owner, and reports a timeout if the engine never completes. It sits between the requesters and the SPI master.

---
 rtl/spi_arbiter_pkg.sv | 16 +
 rtl/spi_arbiter_rr_pick.sv | 34 +++
 rtl/spi_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/spi_arbiter_pkg.sv
// Shared definitions for the SPI engine arbiter: FSM state encoding,
// the SPI word width and the default receive timeout.
package spi_arbiter_pkg;

  localparam int W_CPU           = 32;
  localparam int W_SPI_DATA      = W_CPU;
  localparam int SPI_ARB_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    SPI_ARB_IDLE    = 2'd0,
    SPI_ARB_LAUNCH  = 2'd1,
    SPI_ARB_WAIT_RX = 2'd2,
    SPI_ARB_RESP    = 2'd3
  } spi_arb_state_e;

endpackage

// File: rtl/spi_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate the request vector so the search
// starts just after the previous owner, take the lowest set bit, rotate back.
module spi_arbiter_rr_pick #(
  parameter int N_REQ = 2,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  last_i,
  output logic [ID_W-1:0]  grant_o,
  output logic             any_o
);

  logic [ID_W-1:0]    start;
  logic [ID_W-1:0]    offs;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [ID_W:0]      sum;

  always_comb begin
    start = (last_i == ID_W'(N_REQ - 1)) ? '0 : last_i + ID_W'(1);
    dbl   = {req_i, req_i} >> start;
    rot   = dbl[N_REQ-1:0];
    offs  = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot[j]) offs = ID_W'(j);
    end
    // Un-rotate modulo N_REQ, which need not be a power of two.
    sum = {1'b0, start} + {1'b0, offs};
    if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
    grant_o = sum[ID_W-1:0];
    any_o   = |req_i;
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master engine among N_REQ requesters: round-robin grant,
// load handshake, wait for the received word (or time out), route it back.
module spi_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int W_DATA  = W_SPI_DATA,
  parameter int TIMEOUT = SPI_ARB_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ*W_DATA-1:0]   req_data_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic [N_REQ-1:0]          rsp_valid_o,
  output logic [W_DATA-1:0]         rsp_data_o,
  output logic                      rsp_err_o,
  input  logic                      spi_tx_ready_i,
  output logic                      spi_tx_valid_o,
  output logic [W_DATA-1:0]         spi_tx_data_o,
  input  logic                      spi_rx_valid_i,
  input  logic [W_DATA-1:0]         spi_rx_data_i,
  output logic                      busy_o,
  output logic [$clog2(N_REQ)-1:0]  grant_id_o
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

  spi_arb_state_e    state_q;
  logic [ID_W-1:0]   grant_q;
  logic [ID_W-1:0]   last_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [W_DATA-1:0] tx_data_q;
  logic [W_DATA-1:0] rsp_data_q;
  logic              rsp_err_q;
  logic [N_REQ-1:0]  rsp_valid_q;

  logic [ID_W-1:0]   pick_grant;
  logic              pick_any;
  logic [W_DATA-1:0] pick_data;
  logic              owner_req;
  logic              launch_fire;
  logic [N_REQ-1:0]  owner_onehot;

  spi_arbiter_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req_i   (req_valid_i),
    .last_i  (last_q),
    .grant_o (pick_grant),
    .any_o   (pick_any)
  );

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_grant == ID_W'(i)) pick_data = req_data_i[i*W_DATA +: W_DATA];
    end
  end

  assign owner_req    = req_valid_i[grant_q];
  assign owner_onehot = N_REQ'(1) << grant_q;

  // The load strobe must coincide with the cycle the engine reports ready,
  // so it is decoded from the LAUNCH state and the live handshake inputs.
  assign launch_fire    = (state_q == SPI_ARB_LAUNCH) && owner_req && spi_tx_ready_i;
  assign spi_tx_valid_o = launch_fire;
  assign req_ready_o    = launch_fire ? owner_onehot : '0;
  assign busy_o         = (state_q != SPI_ARB_IDLE);

  assign spi_tx_data_o = tx_data_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_err_o     = rsp_err_q;
  assign grant_id_o    = grant_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SPI_ARB_IDLE;
      grant_q     <= '0;
      last_q      <= ID_LAST;
      cnt_q       <= '0;
      tx_data_q   <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        SPI_ARB_IDLE: begin
          // Latch the word at grant so it is already stable during the strobe.
          if (pick_any) begin
            grant_q   <= pick_grant;
            tx_data_q <= pick_data;
            state_q   <= SPI_ARB_LAUNCH;
          end
        end
        SPI_ARB_LAUNCH: begin
          if (!owner_req) begin
            state_q <= SPI_ARB_IDLE;
          end else if (spi_tx_ready_i) begin
            cnt_q   <= '0;
            state_q <= SPI_ARB_WAIT_RX;
          end
        end
        SPI_ARB_WAIT_RX: begin
          if (spi_rx_valid_i) begin
            rsp_data_q  <= spi_rx_data_i;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= owner_onehot;
            state_q     <= SPI_ARB_RESP;
          end else if (cnt_q == CNT_LAST) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= owner_onehot;
            state_q     <= SPI_ARB_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        SPI_ARB_RESP: begin
          last_q  <= grant_q;
          state_q <= SPI_ARB_IDLE;
        end
        default: state_q <= SPI_ARB_IDLE;
      endcase
    end
  end

endmodule
